writeback_arb: RTL and testbench

//   Registered, parametrised writeback stage. Selects load vs execute data for scalar and vector register-file writes.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/writeback_arb_if.sv | 37 +++
 rtl/wb_conv_fifo.sv | 51 +++++
 rtl/writeback_arb.sv | 108 ++++++++++
 tb/tb_writeback_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths, the conv FIFO entry type and a clog2 helper for the writeback stage.
package wb_pkg;
  localparam int LENGTH      = 16;
  localparam int INT8        = 8;
  localparam int INT32       = 32;
  localparam int VEC_W       = LENGTH * INT8;
  localparam int NREG        = 32;
  localparam int CFIFO_DEPTH = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int AW = clog2(NREG);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [VEC_W-1:0] data;
  } conv_entry_t;
endpackage

// File: rtl/writeback_arb_if.sv
// Pipe, conv and register-file write signals of the writeback stage; master drives, slave is the stage.
interface writeback_arb_if #(
  parameter int AW = wb_pkg::AW,
  parameter int VW = wb_pkg::VEC_W,
  parameter int SW = wb_pkg::INT32
);
  logic [AW-1:0] rD;
  logic          ldr;
  logic [1:0]    wb;
  logic [SW-1:0] s_result;
  logic [SW-1:0] smem;
  logic [VW-1:0] v_result;
  logic [VW-1:0] vmem;
  logic          conv_write;
  logic [AW-1:0] conv_addr;
  logic [VW-1:0] conv_result;
  logic          conv_ready;
  logic          s_write;
  logic [AW-1:0] s_waddr;
  logic [SW-1:0] swrite_data;
  logic          v_write;
  logic [AW-1:0] v_waddr;
  logic [VW-1:0] vwrite_data;
  logic          v_from_conv;
  logic          conv_pending;

  modport master (
    output rD, ldr, wb, s_result, smem, v_result, vmem, conv_write, conv_addr, conv_result,
    input  conv_ready, s_write, s_waddr, swrite_data, v_write, v_waddr, vwrite_data,
           v_from_conv, conv_pending
  );
  modport slave (
    input  rD, ldr, wb, s_result, smem, v_result, vmem, conv_write, conv_addr, conv_result,
    output conv_ready, s_write, s_waddr, swrite_data, v_write, v_waddr, vwrite_data,
           v_from_conv, conv_pending
  );
endinterface

// File: rtl/wb_conv_fifo.sv
// Synchronous FIFO holding conv results; push while full and pop while empty are ignored.
module wb_conv_fifo import wb_pkg::*; #(
  parameter int  DEPTH = CFIFO_DEPTH,
  parameter type T     = conv_entry_t,
  parameter int  CW    = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_din,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int PW = clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/writeback_arb.sv
// Registered writeback: load/execute muxing plus conv FIFO drained into the vector port when the pipe leaves it free.
// Define WB_STATS_EN to add the stall_cnt / max_occ statistics outputs.
module writeback_arb #(
  parameter int LENGTH      = wb_pkg::LENGTH,
  parameter int INT8        = wb_pkg::INT8,
  parameter int INT32       = wb_pkg::INT32,
  parameter int NREG        = wb_pkg::NREG,
  parameter int CFIFO_DEPTH = wb_pkg::CFIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  writeback_arb_if.slave bus
`ifdef WB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt,
  output logic [$clog2(CFIFO_DEPTH):0]  max_occ
`endif
);
  import wb_pkg::*;

  localparam int AW = clog2(NREG);
  localparam int VW = LENGTH * INT8;
  localparam int CW = clog2(CFIFO_DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } entry_t;

  entry_t        w_din, w_head;
  logic          w_full, w_empty, w_push, w_pop;
  logic [CW-1:0] w_count;

  logic             r_s_write, r_v_write, r_v_from_conv;
  logic [AW-1:0]    r_s_waddr, r_v_waddr;
  logic [INT32-1:0] r_sdata;
  logic [VW-1:0]    r_vdata;

  assign w_din  = '{addr: bus.conv_addr, data: bus.conv_result};
  assign w_push = bus.conv_write && !w_full;
  // pipe vector writes always win the port; conv only drains into idle slots
  assign w_pop  = !bus.wb[1] && !w_empty;

  wb_conv_fifo #(.DEPTH(CFIFO_DEPTH), .T(entry_t), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_write     <= 1'b0;
      r_s_waddr     <= '0;
      r_sdata       <= '0;
      r_v_write     <= 1'b0;
      r_v_waddr     <= '0;
      r_vdata       <= '0;
      r_v_from_conv <= 1'b0;
    end else begin
      r_s_write     <= bus.wb[0];
      r_s_waddr     <= bus.rD;
      r_sdata       <= bus.ldr ? bus.smem : bus.s_result;
      r_v_write     <= bus.wb[1] | w_pop;
      r_v_from_conv <= w_pop;
      if (bus.wb[1]) begin
        r_v_waddr <= bus.rD;
        r_vdata   <= bus.ldr ? bus.vmem : bus.v_result;
      end else if (w_pop) begin
        r_v_waddr <= w_head.addr;
        r_vdata   <= w_head.data;
      end
    end
  end

  assign bus.conv_ready   = !w_full;
  assign bus.conv_pending = (w_count != '0);
  assign bus.s_write      = r_s_write;
  assign bus.s_waddr      = r_s_waddr;
  assign bus.swrite_data  = r_sdata;
  assign bus.v_write      = r_v_write;
  assign bus.v_waddr      = r_v_waddr;
  assign bus.vwrite_data  = r_vdata;
  assign bus.v_from_conv  = r_v_from_conv;

`ifdef WB_STATS_EN
  logic [15:0]   r_stall_cnt;
  logic [CW-1:0] r_max_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_max_occ   <= '0;
    end else begin
      if (bus.wb[1] && !w_empty && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_count > r_max_occ) r_max_occ <= w_count;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign max_occ   = r_max_occ;
`endif
endmodule

// File: tb/tb_writeback_arb.sv
// Directed and random checks of writeback_arb against a queue-based model of the pipe/conv rules.
module tb_writeback_arb;
  import wb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  writeback_arb_if bus ();

`ifdef WB_STATS_EN
  logic [15:0]                  stall_cnt;
  logic [clog2(CFIFO_DEPTH):0]  max_occ;
`endif

  writeback_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .max_occ   (max_occ)
`endif
  );

  // reference model state
  conv_entry_t      q[$];
  logic             e_sw, e_vw, e_fc;
  logic [AW-1:0]    e_sa, e_va;
  logic [INT32-1:0] e_sd;
  logic [VEC_W-1:0] e_vd;
  bit               m_acc;
  int               m_stall, m_max;
  int               vectors = 0;
  int               errs    = 0;

  task automatic chk(string tag, logic [VEC_W-1:0] obs, logic [VEC_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rvec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    e_sw = 1'b0; e_vw = 1'b0; e_fc = 1'b0;
    e_sa = '0; e_va = '0; e_sd = '0; e_vd = '0;
    m_acc = 1'b0; m_stall = 0; m_max = 0;
  endtask

  // One clock edge of the stage as the rules describe it
  task automatic model_edge();
    conv_entry_t h;
    bit full;
    full = (q.size() == CFIFO_DEPTH);
    if (bus.wb[1] && q.size() > 0) m_stall++;
    e_sw = bus.wb[0];
    e_sa = bus.rD;
    e_sd = bus.ldr ? bus.smem : bus.s_result;
    e_vw = bus.wb[1];
    e_fc = 1'b0;
    if (bus.wb[1]) begin
      e_va = bus.rD;
      e_vd = bus.ldr ? bus.vmem : bus.v_result;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      e_vw = 1'b1; e_fc = 1'b1; e_va = h.addr; e_vd = h.data;
    end
    m_acc = bus.conv_write && !full;
    if (m_acc) q.push_back('{addr: bus.conv_addr, data: bus.conv_result});
    if (q.size() > m_max) m_max = q.size();
  endtask

  task automatic check_all();
    chk("s_write",      VEC_W'(bus.s_write),      VEC_W'(e_sw));
    chk("v_write",      VEC_W'(bus.v_write),      VEC_W'(e_vw));
    chk("v_from_conv",  VEC_W'(bus.v_from_conv),  VEC_W'(e_fc));
    chk("conv_ready",   VEC_W'(bus.conv_ready),   VEC_W'(q.size() < CFIFO_DEPTH));
    chk("conv_pending", VEC_W'(bus.conv_pending), VEC_W'(q.size() != 0));
    if (e_sw) begin
      chk("s_waddr",     VEC_W'(bus.s_waddr),     VEC_W'(e_sa));
      chk("swrite_data", VEC_W'(bus.swrite_data), VEC_W'(e_sd));
    end
    if (e_vw) begin
      chk("v_waddr",     VEC_W'(bus.v_waddr), VEC_W'(e_va));
      chk("vwrite_data", bus.vwrite_data,     e_vd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_pipe(bit allow_v);
    bus.rD       = AW'($urandom);
    bus.ldr      = 1'($urandom);
    bus.wb       = 2'($urandom);
    if (!allow_v) bus.wb[1] = 1'b0;
    bus.s_result = $urandom;
    bus.smem     = $urandom;
    bus.v_result = rvec();
    bus.vmem     = rvec();
  endtask

  // conv source holds each item until the stage accepts it
  task automatic cycle(int conv_pct);
    if (!bus.conv_write && $urandom_range(99) < conv_pct) begin
      bus.conv_write  = 1'b1;
      bus.conv_addr   = AW'($urandom);
      bus.conv_result = rvec();
    end
    step();
    if (m_acc) bus.conv_write = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_write",      VEC_W'(bus.s_write),      '0);
    chk("rst_v_write",      VEC_W'(bus.v_write),      '0);
    chk("rst_v_from_conv",  VEC_W'(bus.v_from_conv),  '0);
    chk("rst_conv_pending", VEC_W'(bus.conv_pending), '0);
    chk("rst_swrite_data",  VEC_W'(bus.swrite_data),  '0);
    chk("rst_vwrite_data",  bus.vwrite_data,          '0);
`ifdef WB_STATS_EN
    chk("rst_stall_cnt",    VEC_W'(stall_cnt),        '0);
    chk("rst_max_occ",      VEC_W'(max_occ),          '0);
`endif
  endtask

  initial begin
    int acc;
    int sent;
    bus.rD = '0; bus.ldr = 1'b0; bus.wb = 2'b00;
    bus.s_result = '0; bus.smem = '0; bus.v_result = '0; bus.vmem = '0;
    bus.conv_write = 1'b0; bus.conv_addr = '0; bus.conv_result = '0;
    model_reset();

    // power-on reset
    #1 rst_n = 1'b0;
    #11;
    check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_reset", VEC_W'(bus.conv_ready), VEC_W'(1));

    // pipe load path, both files
    rand_pipe(1'b1);
    bus.ldr = 1'b1; bus.wb = 2'b11; bus.rD = 5'd5; bus.smem = 32'hDEAD_BEEF;
    step();
    chk("load_sdata", VEC_W'(bus.swrite_data), VEC_W'(32'hDEAD_BEEF));
    chk("load_vaddr", VEC_W'(bus.v_waddr),     VEC_W'(5));

    // pipe execute path
    rand_pipe(1'b1);
    bus.ldr = 1'b0; bus.wb = 2'b01;
    step();

    // single conv result into an idle vector port
    bus.wb = 2'b00;
    bus.conv_write = 1'b1; bus.conv_addr = 5'd7; bus.conv_result = rvec();
    step();
    bus.conv_write = 1'b0;
    chk("conv_not_yet", VEC_W'(bus.v_write), '0);
    step();
    chk("conv_idle_addr", VEC_W'(bus.v_waddr),     VEC_W'(7));
    chk("conv_idle_src",  VEC_W'(bus.v_from_conv), VEC_W'(1));

    // contention: pipe holds the vector port for 5 cycles
    for (int k = 0; k < 5; k++) begin
      rand_pipe(1'b1);
      bus.wb[1] = 1'b1;
      bus.conv_write = (k < 3);
      bus.conv_addr  = AW'(10 + k);
      bus.conv_result = rvec();
      step();
      chk("contend_no_conv", VEC_W'(bus.v_from_conv), '0);
    end
    bus.conv_write = 1'b0;
    chk("contend_pending", VEC_W'(bus.conv_pending), VEC_W'(1));
    for (int k = 0; k < 3; k++) begin
      rand_pipe(1'b0);
      step();
      chk("drain_order", VEC_W'(bus.v_waddr), VEC_W'(10 + k));
      chk("drain_src",   VEC_W'(bus.v_from_conv), VEC_W'(1));
    end

    // full FIFO: five pushes against a stalled port
    acc = 0; sent = 0;
    for (int k = 0; k < 14; k++) begin
      rand_pipe(k < 7);
      if (k < 7) bus.wb[1] = 1'b1;
      if (!bus.conv_write && sent < 5) begin
        bus.conv_write = 1'b1; bus.conv_addr = AW'(20 + sent); bus.conv_result = rvec();
        sent++;
      end
      step();
      if (m_acc) begin
        bus.conv_write = 1'b0;
        acc++;
        if (acc == 4) chk("full_not_ready", VEC_W'(bus.conv_ready), '0);
      end
    end
    chk("full_all_accepted", VEC_W'(acc), VEC_W'(5));
`ifdef WB_STATS_EN
    chk("max_occ_full", VEC_W'(max_occ),   VEC_W'(4));
    chk("stall_cnt",    VEC_W'(stall_cnt), VEC_W'(m_stall));
`endif

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_pipe(1'b1);
      cycle(40);
    end

    // reset in the middle of traffic discards the FIFO
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    bus.conv_write = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_midreset", VEC_W'(bus.conv_ready), VEC_W'(1));

    for (int k = 0; k < 300; k++) begin
      rand_pipe($urandom_range(99) < 70);
      cycle(60);
    end
    bus.conv_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rand_pipe(1'b0);
      step();
    end
`ifdef WB_STATS_EN
    chk("stall_cnt_end", VEC_W'(stall_cnt), VEC_W'(m_stall));
    chk("max_occ_end",   VEC_W'(max_occ),   VEC_W'(m_max));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
